// File: rtl/prng_block_gen.sv
// prng_block_gen: parametrised LFSR random block generator with seed load,
// one-shot/continuous modes, valid/ready output handshake and sticky error.
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   seed_we, seed_i   seed load strobe and value (honoured in IDLE only)
//   start_i, mode_i   start request (IDLE only); 0 = one-shot, 1 = continuous
//   ready_i           consumer accepts data_o
//   data_o, valid_o   generated block and its valid flag
//   busy_o, err_o     generator not idle; sticky error (zero seed / seed while busy)
module prng_block_gen #(
    parameter int                LFSR_W       = 64,
    parameter logic [LFSR_W-1:0] TAPS         = 64'hD800_0000_0000_0000,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 64'h0000_0000_0000_0001,
    parameter int                BITS_PER_CYC = 1,
    parameter int                OUT_W        = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_we,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic              ready_i,
    output logic [OUT_W-1:0]  data_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              err_o
);
    localparam int N  = OUT_W / BITS_PER_CYC;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_e;

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
    logic [OUT_W-1:0]  sh_q, sh_d, sh_step, data_q, data_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valid_q, valid_d, err_q, err_d;

    // BITS_PER_CYC single-bit steps chained in order, so any step count
    // produces the same bit stream as one step per clock.
    always_comb begin
        lfsr_step = lfsr_q;
        sh_step   = sh_q;
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            sh_step   = (sh_step << 1) | OUT_W'(lfsr_step[0]);
            lfsr_step = {lfsr_step[LFSR_W-2:0], ^(lfsr_step & TAPS)};
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        sh_d    = sh_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = err_q | (seed_we & ((state_q != IDLE) | (seed_i == '0)));
        case (state_q)
            IDLE: begin
                if (seed_we) begin
                    lfsr_d = (seed_i != '0) ? seed_i : lfsr_q;
                end else if (start_i) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                lfsr_d = lfsr_step;
                sh_d   = sh_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    data_d  = sh_step;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = mode_i ? FILL : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= DEFAULT_SEED;
            sh_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy_o  = (state_q != IDLE);
    assign err_o   = err_q;
endmodule

// File: tb/tb_prng_block_gen.sv
// tb_prng_block_gen: scoreboard bench for prng_block_gen; two 8-bit instances
// (1 and 2 steps per clock) share stimulus, plus one default 64/1024 instance.
module tb_prng_block_gen;
    logic clk = 0, rst_n = 0;
    logic seed_we = 0, start = 0, mode = 0, ready = 0;
    logic [7:0] seed = 0;
    logic [7:0] data_a, data_b;
    logic valid_a, valid_b, busy_a, busy_b, err_a, err_b;
    logic seed_we_c = 0, start_c = 0, mode_c = 0, ready_c = 0;
    logic [63:0] seed_c = 0;
    logic [1023:0] data_c;
    logic valid_c, busy_c, err_c;

    int checks = 0, errors = 0, cyc = 0;
    logic [7:0] m8 = 8'h01;
    logic [63:0] m64 = 64'h1;
    logic [7:0] q_s[2][$];
    logic [1023:0] q_c[$];
    logic [1023:0] seen[$];
    bit idle[2] = '{1, 1};
    bit pv[2], pr[2];
    int arm[2];
    logic [7:0] held[2];
    bit idle_c = 1, pv_c = 0;
    int arm_c = 0, pops_c = 0;

    prng_block_gen #(.LFSR_W(8), .TAPS(8'hB8), .DEFAULT_SEED(8'h01), .BITS_PER_CYC(1), .OUT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .seed_we(seed_we), .seed_i(seed), .start_i(start), .mode_i(mode),
        .ready_i(ready), .data_o(data_a), .valid_o(valid_a), .busy_o(busy_a), .err_o(err_a));
    prng_block_gen #(.LFSR_W(8), .TAPS(8'hB8), .DEFAULT_SEED(8'h01), .BITS_PER_CYC(2), .OUT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .seed_we(seed_we), .seed_i(seed), .start_i(start), .mode_i(mode),
        .ready_i(ready), .data_o(data_b), .valid_o(valid_b), .busy_o(busy_b), .err_o(err_b));
    prng_block_gen u_c (
        .clk(clk), .rst_n(rst_n), .seed_we(seed_we_c), .seed_i(seed_c), .start_i(start_c), .mode_i(mode_c),
        .ready_i(ready_c), .data_o(data_c), .valid_o(valid_c), .busy_o(busy_c), .err_o(err_c));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: spec-level LFSR; the first bit produced lands in the block MSB.
    function automatic logic [7:0] gen8();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[7-i] = m8[0];
            m8 = {m8[6:0], ^(m8 & 8'hB8)};
        end
        return b;
    endfunction

    function automatic logic [1023:0] gen1024();
        logic [1023:0] b;
        for (int i = 0; i < 1024; i++) begin
            b[1023-i] = m64[0];
            m64 = {m64[62:0], ^(m64 & 64'hD800_0000_0000_0000)};
        end
        return b;
    endfunction

    task automatic push8();
        logic [7:0] e;
        e = gen8();
        q_s[0].push_back(e);
        q_s[1].push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [7:0] d[2];
        bit v[2], b[2];
        logic [1023:0] e;
        if (!rst_n) return;
        d = '{data_a, data_b};
        v = '{valid_a, valid_b};
        b = '{busy_a, busy_b};
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("busy_%0d", k), 64'(b[k]), 64'(!idle[k]));
            if (idle[k] && start && !seed_we) begin
                arm[k] = cyc + 1;
                idle[k] = 0;
            end
            if (v[k] && !pv[k]) begin
                chk($sformatf("latency_%0d", k), 64'(cyc - arm[k]), 64'(k ? 4 : 8));
                if (q_s[k].size() == 0) chk($sformatf("spurious_valid_%0d", k), 64'(v[k]), 64'd0);
                else chk($sformatf("data_%0d", k), 64'(d[k]), 64'(q_s[k].pop_front()));
                held[k] = d[k];
            end else if (pv[k] && !pr[k]) begin
                chk($sformatf("hold_valid_%0d", k), 64'(v[k]), 64'd1);
                chk($sformatf("hold_data_%0d", k), 64'(d[k]), 64'(held[k]));
            end else if (pv[k] && pr[k]) begin
                chk($sformatf("valid_drop_%0d", k), 64'(v[k]), 64'd0);
            end
            if (v[k] && ready) begin
                if (mode) arm[k] = cyc + 1;
                else idle[k] = 1;
            end
            pv[k] = v[k];
            pr[k] = ready;
        end
        chk("busy_c", 64'(busy_c), 64'(!idle_c));
        if (idle_c && start_c) begin
            arm_c = cyc + 1;
            idle_c = 0;
        end
        if (valid_c && !pv_c) begin
            chk("latency_c", 64'(cyc - arm_c), 64'd1024);
            if (q_c.size() == 0) chk("spurious_valid_c", 64'(valid_c), 64'd0);
            else begin
                e = q_c.pop_front();
                checks++;
                if (data_c !== e) begin
                    errors++;
                    $display("FAIL data_c: got low %h expected low %h", data_c[63:0], e[63:0]);
                end
                foreach (seen[j]) chk("distinct_c", 64'(data_c == seen[j]), 64'd0);
                seen.push_back(data_c);
                pops_c++;
            end
        end
        if (valid_c && ready_c) begin
            if (mode_c) arm_c = cyc + 1;
            else idle_c = 1;
        end
        pv_c = valid_c;
    endtask

    task automatic flush_model();
        m8 = 8'h01;
        m64 = 64'h1;
        idle = '{1, 1};
        idle_c = 1;
        pv = '{0, 0};
        pr = '{0, 0};
        pv_c = 0;
        q_s[0].delete();
        q_s[1].delete();
        q_c.delete();
    endtask

    task automatic do_reset();
        rst_n = 0;
        flush_model();
        tick();
        rst_n = 1;
    endtask

    task automatic load_seed(input logic [7:0] v);
        seed_we = 1;
        seed = v;
        tick();
        seed_we = 0;
        if (v != 0) m8 = v;
    endtask

    task automatic pulse_start(input bit md);
        start = 1;
        mode = md;
        tick();
        start = 0;
    endtask

    task automatic wait_valid_both(input int bound);
        int t = 0;
        while (!(valid_a && valid_b) && t < bound) begin
            tick();
            t++;
        end
        chk("wait_valid", 64'(valid_a && valid_b), 64'd1);
    endtask

    task automatic wait_idle(input int bound);
        int t = 0;
        while (!(idle[0] && idle[1]) && t < bound) begin
            tick();
            t++;
        end
        chk("wait_idle", 64'(idle[0] && idle[1]), 64'd1);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                monitor();
            end
        join_none
        #12;
        chk("rst_data_a", 64'(data_a), 0);
        chk("rst_valid_a", 64'(valid_a), 0);
        chk("rst_busy_b", 64'(busy_b), 0);
        chk("rst_err_b", 64'(err_b), 0);
        chk("rst_data_c", 64'(data_c != '0), 0);
        chk("rst_valid_c", 64'(valid_c), 0);
        tick();
        rst_n = 1;
        // one-shot from seed 01, consumer stalls in HOLD
        load_seed(8'h01);
        push8();
        pulse_start(0);
        wait_valid_both(20);
        tick(5);
        ready = 1;
        tick();
        ready = 0;
        wait_idle(20);
        chk("idle_busy_a", 64'(busy_a), 0);
        chk("idle_busy_b", 64'(busy_b), 0);
        // continuous: stall, handshake, second block continues the LFSR
        load_seed(8'h01);
        push8();
        push8();
        pulse_start(1);
        wait_valid_both(20);
        tick(5);
        mode = 1;
        ready = 1;
        tick();
        mode = 0;
        wait_idle(40);
        // zero seed sets err and keeps the LFSR
        do_reset();
        load_seed(8'h00);
        chk("zero_seed_err_a", 64'(err_a), 1);
        chk("zero_seed_err_b", 64'(err_b), 1);
        push8();
        pulse_start(0);
        wait_idle(20);
        // seed_we during FILL flags err, block unaffected
        do_reset();
        chk("err_cleared_a", 64'(err_a), 0);
        push8();
        pulse_start(0);
        tick(2);
        seed_we = 1;
        seed = 8'h55;
        tick();
        seed_we = 0;
        chk("fill_seed_err_a", 64'(err_a), 1);
        chk("fill_seed_err_b", 64'(err_b), 1);
        wait_idle(20);
        // seed_we wins over start in the same cycle
        seed_we = 1;
        seed = 8'h37;
        start = 1;
        tick();
        seed_we = 0;
        start = 0;
        m8 = 8'h37;
        tick();
        chk("seed_start_busy_a", 64'(busy_a), 0);
        chk("seed_start_busy_b", 64'(busy_b), 0);
        push8();
        pulse_start(0);
        wait_idle(20);
        // async reset mid-FILL
        push8();
        pulse_start(0);
        tick(3);
        rst_n = 0;
        #1;
        chk("async_data_a", 64'(data_a), 0);
        chk("async_valid_a", 64'(valid_a), 0);
        chk("async_busy_a", 64'(busy_a), 0);
        chk("async_err_a", 64'(err_a), 0);
        chk("async_data_b", 64'(data_b), 0);
        chk("async_busy_b", 64'(busy_b), 0);
        flush_model();
        tick();
        rst_n = 1;
        push8();
        pulse_start(0);
        wait_idle(20);
        // default configuration: three continuous 1024-bit blocks
        ready_c = 1;
        mode_c = 1;
        for (int i = 0; i < 3; i++) q_c.push_back(gen1024());
        start_c = 1;
        tick();
        start_c = 0;
        for (int t = 0; t < 3000 && pops_c < 2; t++) tick();
        chk("big_two_blocks", 64'(pops_c >= 2), 1);
        mode_c = 0;
        for (int t = 0; t < 2000 && !idle_c; t++) tick();
        chk("big_idle", 64'(idle_c), 1);
        tick(2);
        chk("big_busy", 64'(busy_c), 0);
        chk("q_a_empty", 64'(q_s[0].size()), 0);
        chk("q_b_empty", 64'(q_s[1].size()), 0);
        chk("q_c_empty", 64'(q_c.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
